// File: rtl/sobel_lb_pkg.sv
// Shared constants, FSM encoding and gradient sizing for the line-buffered Sobel engine.
package sobel_lb_pkg;
  localparam logic [1:0] CSEL_IDLE = 2'b00;
  localparam logic [1:0] CSEL_X    = 2'b01;
  localparam logic [1:0] CSEL_Y    = 2'b10;
  localparam logic [1:0] CSEL_C    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  // Signed gradient width: worst case |G| = 4*(2^DW-1) plus sign.
  function automatic int grad_w(input int dw);
    return dw + 4;
  endfunction
endpackage

// File: rtl/sobel_linebuf.sv
// Two-row circular line buffer; one shared pointer, up1 = one row back, up2 = two rows back.
module sobel_linebuf
  import sobel_lb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 257
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] up1,
  output logic [DW-1:0] up2
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] ptr;
  logic [DW-1:0] row1 [DEPTH];
  logic [DW-1:0] row2 [DEPTH];

  assign up1 = row1[ptr];
  assign up2 = row2[ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   ptr <= '0;
    else if (en) ptr <= (ptr == PW'(DEPTH-1)) ? '0 : ptr + 1'b1;
  end

  // Storage is never cleared; the consumer masks rows that are not yet valid.
  always_ff @(posedge clk) begin
    if (en) begin
      row1[ptr] <= din;
      row2[ptr] <= row1[ptr];
    end
  end
endmodule

// File: rtl/sobel_lb.sv
// Streaming Sobel engine: one read per virtual raster position, 3x3 window, X/Y/combined writes.
module sobel_lb
  import sobel_lb_pkg::*;
#(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int DW      = 8,
  parameter int USE_ABS = 0,
  parameter int AW      = $clog2(IMG_W*IMG_H)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic [2:0]    out_en,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic          cwr,
  output logic [1:0]    csel,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr
);
  localparam int GW = grad_w(DW);
  localparam int CW = $clog2(IMG_W+1);
  localparam int RW = $clog2(IMG_H+1);
  localparam logic [AW-1:0]        LAST_ADDR = AW'(IMG_W*IMG_H-1);
  localparam logic signed [GW-1:0] MAXV      = GW'((1 << DW) - 1);

  state_t state_q, state_d;
  logic [RW-1:0] vr;
  logic [CW-1:0] vc;
  logic [2:0]    en_r, rem, cur, rem_nx;
  logic          fin;
  logic [AW-1:0] oaddr;
  logic [8:0][DW-1:0] win, pm;
  logic [2:0]    cvalid;
  logic          in_range, row_end, last_pos, out_due;
  logic [DW-1:0] pix, up1, up2;
  logic [1:0]    cur_sel;
  logic signed [GW-1:0] gx, gy;
  logic [DW-1:0] xs, ys, cs, wval;
  logic [DW:0]   csum;

  assign in_range = (vr < RW'(IMG_H)) && (vc < CW'(IMG_W));
  assign pix      = in_range ? idata : '0;
  assign row_end  = (vc == CW'(IMG_W));
  assign last_pos = row_end && (vr == RW'(IMG_H));
  assign out_due  = (vr != '0) && (vc != '0);

  sobel_linebuf #(.DW(DW), .DEPTH(IMG_W+1)) u_lb (
    .clk  (clk),
    .reset(reset),
    .en   (state_q == S_READ),
    .din  (pix),
    .up1  (up1),
    .up2  (up2)
  );

  function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] v);
    return {{(GW-DW){1'b0}}, v};
  endfunction

  function automatic logic [DW-1:0] sat(input logic signed [GW-1:0] g);
    logic signed [GW-1:0] m;
    m = (USE_ABS != 0 && g < 0) ? -g : g;
    if (m < 0)    return '0;
    if (m > MAXV) return '1;
    return m[DW-1:0];
  endfunction

  always_comb begin
    pm = '0;
    for (int i = 0; i < 9; i++) pm[i] = cvalid[i%3] ? win[i] : '0;
    gx   = ext(pm[0]) + (ext(pm[3]) <<< 1) + ext(pm[6])
         - ext(pm[2]) - (ext(pm[5]) <<< 1) - ext(pm[8]);
    gy   = ext(pm[0]) + (ext(pm[1]) <<< 1) + ext(pm[2])
         - ext(pm[6]) - (ext(pm[7]) <<< 1) - ext(pm[8]);
    xs   = sat(gx);
    ys   = sat(gy);
    csum = {1'b0, xs} + {1'b0, ys} + (DW+1)'(1);
    cs   = DW'(csum >> 1);
  end

  // Layers go out lowest enabled bit first: X, Y, combined.
  assign cur     = rem & (~rem + 3'd1);
  assign rem_nx  = rem & ~cur;
  assign cur_sel = cur[0] ? CSEL_X : (cur[1] ? CSEL_Y : CSEL_C);
  assign wval    = cur[0] ? xs : (cur[1] ? ys : cs);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ready && !busy) state_d = S_READ;
      S_READ:  if (out_due)        state_d = S_WRITE;
               else if (last_pos)  state_d = S_DONE;
      S_WRITE: if (rem_nx == '0)   state_d = fin ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0; cwr <= 1'b0; csel <= CSEL_IDLE;
      iaddr <= '0; caddr_wr <= '0; cdata_wr <= '0;
      vr <= '0; vc <= '0; en_r <= '0; rem <= '0; fin <= 1'b0;
      oaddr <= '0; win <= '0; cvalid <= '0;
    end else begin
      cwr  <= 1'b0;
      csel <= CSEL_IDLE;
      unique case (state_q)
        S_IDLE: if (ready && !busy) begin
          busy  <= 1'b1;
          en_r  <= (out_en == 3'b000) ? 3'b111 : out_en;
          vr    <= '0;
          vc    <= '0;
          iaddr <= '0;
          oaddr <= '0;
        end
        S_READ: begin
          for (int rr = 0; rr < 3; rr++) begin
            win[rr*3]   <= win[rr*3+1];
            win[rr*3+1] <= win[rr*3+2];
          end
          win[2] <= (vr >= RW'(2)) ? up2 : '0;
          win[5] <= (vr != '0)     ? up1 : '0;
          win[8] <= pix;
          // Row start: only the incoming column is real, so nothing from the previous row leaks in.
          cvalid <= (vc == '0) ? 3'b100 : {1'b1, cvalid[2:1]};
          if (row_end) begin
            vc <= '0;
            vr <= vr + 1'b1;
          end else begin
            vc <= vc + 1'b1;
          end
          if (in_range && iaddr != LAST_ADDR) iaddr <= iaddr + 1'b1;
          if (out_due) begin
            rem <= en_r;
            fin <= last_pos;
          end
        end
        S_WRITE: begin
          cwr      <= 1'b1;
          csel     <= cur_sel;
          caddr_wr <= oaddr;
          cdata_wr <= wval;
          rem      <= rem_nx;
          if (rem_nx == '0) oaddr <= oaddr + 1'b1;
        end
        S_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_lb.sv
// Directed bench for sobel_lb: 4x4 clamp/abs instances and an 8x8 abs instance with a padded-convolution reference.
module tb_sobel_lb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       ready, busy, cwr;
  logic [2:0][2:0]  out_en;
  logic [2:0][1:0]  csel;
  logic [2:0][7:0]  cdata, idata;
  logic [3:0] iaddr_a, iaddr_b, caddr_a, caddr_b;
  logic [5:0] iaddr_c, caddr_c;
  logic [7:0] mem4 [16];
  logic [7:0] mem8 [64];

  assign idata[0] = mem4[iaddr_a];
  assign idata[1] = mem4[iaddr_b];
  assign idata[2] = mem8[iaddr_c];

  sobel_lb #(.IMG_W(4), .IMG_H(4), .DW(8), .USE_ABS(0)) dut_a (
    .clk(clk), .reset(reset), .ready(ready[0]), .out_en(out_en[0]), .busy(busy[0]),
    .iaddr(iaddr_a), .idata(idata[0]), .cwr(cwr[0]), .csel(csel[0]),
    .caddr_wr(caddr_a), .cdata_wr(cdata[0]));
  sobel_lb #(.IMG_W(4), .IMG_H(4), .DW(8), .USE_ABS(1)) dut_b (
    .clk(clk), .reset(reset), .ready(ready[1]), .out_en(out_en[1]), .busy(busy[1]),
    .iaddr(iaddr_b), .idata(idata[1]), .cwr(cwr[1]), .csel(csel[1]),
    .caddr_wr(caddr_b), .cdata_wr(cdata[1]));
  sobel_lb #(.IMG_W(8), .IMG_H(8), .DW(8), .USE_ABS(1)) dut_c (
    .clk(clk), .reset(reset), .ready(ready[2]), .out_en(out_en[2]), .busy(busy[2]),
    .iaddr(iaddr_c), .idata(idata[2]), .cwr(cwr[2]), .csel(csel[2]),
    .caddr_wr(caddr_c), .cdata_wr(cdata[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int q_k[$], q_sel[$], q_addr[$], q_dat[$];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (cwr[k]) begin
        q_k.push_back(k);
        q_sel.push_back(int'(csel[k]));
        q_addr.push_back(k == 0 ? int'(caddr_a) : (k == 1 ? int'(caddr_b) : int'(caddr_c)));
        q_dat.push_back(int'(cdata[k]));
      end
    end
  end

  function automatic void clear_log();
    q_k.delete(); q_sel.delete(); q_addr.delete(); q_dat.delete();
  endfunction

  function automatic int nwr(input int k);
    int n = 0;
    foreach (q_k[i]) if (q_k[i] == k) n++;
    return n;
  endfunction

  function automatic int lookup(input int k, input int sel, input int addr);
    int v = -1;
    foreach (q_k[i]) if (q_k[i] == k && q_sel[i] == sel && q_addr[i] == addr) v = q_dat[i];
    return v;
  endfunction

  function automatic int order_errs(input int k);
    int n = 0, j = 0;
    foreach (q_k[i]) if (q_k[i] == k) begin
      if (q_sel[i] != 1 + j % 3 || q_addr[i] != j / 3) n++;
      j++;
    end
    return n;
  endfunction

  function automatic int px8(input int r, input int c);
    if (r < 0 || r > 7 || c < 0 || c > 7) return 0;
    return int'(mem8[r*8+c]);
  endfunction

  function automatic int sat_abs(input int g);
    if (g < 0) g = -g;
    return (g > 255) ? 255 : g;
  endfunction

  function automatic int gold8(input int sel, input int r, input int c);
    int gx, gy, x, y;
    gx = px8(r-1,c-1) + 2*px8(r,c-1) + px8(r+1,c-1) - px8(r-1,c+1) - 2*px8(r,c+1) - px8(r+1,c+1);
    gy = px8(r-1,c-1) + 2*px8(r-1,c) + px8(r-1,c+1) - px8(r+1,c-1) - 2*px8(r+1,c) - px8(r+1,c+1);
    x = sat_abs(gx);
    y = sat_abs(gy);
    return (sel == 1) ? x : (sel == 2) ? y : (x + y + 1) / 2;
  endfunction

  task automatic run(input int k, input logic [2:0] en, output int len);
    clear_log();
    @(posedge clk); #1;
    ready[k] = 1'b1; out_en[k] = en;
    @(posedge clk); #1;
    ready[k] = 1'b0;
    len = 0;
    while (busy[k] && len < 2000) begin
      len++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    if (busy !== 3'b000)  begin n_bad++; $display("FAIL reset_busy got %b want 000", busy); end
    n_cmp++;
    if (cwr !== 3'b000)   begin n_bad++; $display("FAIL reset_cwr got %b want 000", cwr); end
    n_cmp++;
    if (csel[0] !== 2'b00) begin n_bad++; $display("FAIL reset_csel got %b want 00", csel[0]); end
    n_cmp++;
    if (iaddr_a !== 4'd0 || iaddr_c !== 6'd0) begin n_bad++; $display("FAIL reset_iaddr got %0d/%0d want 0", iaddr_a, iaddr_c); end
    n_cmp++;
    if (caddr_a !== 4'd0 || cdata[0] !== 8'd0) begin n_bad++; $display("FAIL reset_cout got %0d/%0d want 0", caddr_a, cdata[0]); end
    n_cmp++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_flat4();
    int len;
    for (int i = 0; i < 16; i++) mem4[i] = 8'd100;
    run(0, 3'b111, len);
    if (len !== 74) begin n_bad++; $display("FAIL flat4_len got %0d want 74", len); end
    n_cmp++;
    if (nwr(0) !== 48) begin n_bad++; $display("FAIL flat4_writes got %0d want 48", nwr(0)); end
    n_cmp++;
    if (order_errs(0) !== 0) begin n_bad++; $display("FAIL flat4_order got %0d bad want 0", order_errs(0)); end
    n_cmp++;
    for (int s = 1; s <= 3; s++) begin
      if (lookup(0, s, 0) !== 0) begin n_bad++; $display("FAIL flat4_00_sel%0d got %0d want 0", s, lookup(0, s, 0)); end
      n_cmp++;
      if (lookup(0, s, 5) !== 0) begin n_bad++; $display("FAIL flat4_11_sel%0d got %0d want 0", s, lookup(0, s, 5)); end
      n_cmp++;
    end
    // top-right corner: Gx=+300 saturates, Gy=-300 clamps, C=(255+0+1)>>1
    if (lookup(0, 1, 3) !== 255) begin n_bad++; $display("FAIL flat4_03_x got %0d want 255", lookup(0, 1, 3)); end
    n_cmp++;
    if (lookup(0, 2, 3) !== 0) begin n_bad++; $display("FAIL flat4_03_y got %0d want 0", lookup(0, 2, 3)); end
    n_cmp++;
    if (lookup(0, 3, 3) !== 128) begin n_bad++; $display("FAIL flat4_03_c got %0d want 128", lookup(0, 3, 3)); end
    n_cmp++;
  endtask

  task automatic test_abs4();
    int len;
    run(1, 3'b000, len);
    if (len !== 74) begin n_bad++; $display("FAIL abs4_len got %0d want 74", len); end
    n_cmp++;
    if (nwr(1) !== 48) begin n_bad++; $display("FAIL abs4_writes got %0d want 48", nwr(1)); end
    n_cmp++;
    for (int s = 1; s <= 3; s++) begin
      if (lookup(1, s, 0) !== 255) begin n_bad++; $display("FAIL abs4_00_sel%0d got %0d want 255", s, lookup(1, s, 0)); end
      n_cmp++;
      if (lookup(1, s, 5) !== 0) begin n_bad++; $display("FAIL abs4_11_sel%0d got %0d want 0", s, lookup(1, s, 5)); end
      n_cmp++;
    end
  endtask

  task automatic check_gold8(input string tag);
    foreach (q_k[i]) if (q_k[i] == 2) begin
      if (q_dat[i] !== gold8(q_sel[i], q_addr[i] / 8, q_addr[i] % 8)) begin
        n_bad++;
        $display("FAIL %s sel%0d addr%0d got %0d want %0d", tag, q_sel[i], q_addr[i], q_dat[i],
                 gold8(q_sel[i], q_addr[i] / 8, q_addr[i] % 8));
      end
      n_cmp++;
    end
  endtask

  task automatic test_edge8();
    int len;
    for (int i = 0; i < 64; i++) mem8[i] = (i % 8 >= 4) ? 8'd200 : 8'd0;
    run(2, 3'b111, len);
    if (len !== 274) begin n_bad++; $display("FAIL edge8_len got %0d want 274", len); end
    n_cmp++;
    if (nwr(2) !== 192) begin n_bad++; $display("FAIL edge8_writes got %0d want 192", nwr(2)); end
    n_cmp++;
    if (order_errs(2) !== 0) begin n_bad++; $display("FAIL edge8_order got %0d bad want 0", order_errs(2)); end
    n_cmp++;
    if (lookup(2, 1, 27) !== 255) begin n_bad++; $display("FAIL edge8_33_x got %0d want 255", lookup(2, 1, 27)); end
    n_cmp++;
    if (lookup(2, 2, 27) !== 0) begin n_bad++; $display("FAIL edge8_33_y got %0d want 0", lookup(2, 2, 27)); end
    n_cmp++;
    if (lookup(2, 3, 27) !== 128) begin n_bad++; $display("FAIL edge8_33_c got %0d want 128", lookup(2, 3, 27)); end
    n_cmp++;
    check_gold8("edge8_gold");
  endtask

  task automatic test_y_only();
    int len, nony;
    for (int i = 0; i < 64; i++) mem8[i] = 8'($urandom_range(0, 255));
    run(2, 3'b010, len);
    if (len !== 146) begin n_bad++; $display("FAIL yonly_len got %0d want 146", len); end
    n_cmp++;
    if (nwr(2) !== 64) begin n_bad++; $display("FAIL yonly_writes got %0d want 64", nwr(2)); end
    n_cmp++;
    nony = 0;
    foreach (q_k[i]) if (q_k[i] == 2 && q_sel[i] != 2) nony++;
    if (nony !== 0) begin n_bad++; $display("FAIL yonly_sel got %0d non-Y want 0", nony); end
    n_cmp++;
    check_gold8("yonly_gold");
  endtask

  task automatic test_reset_mid();
    int len;
    for (int i = 0; i < 64; i++) mem8[i] = 8'd250;
    @(posedge clk); #1;
    ready[2] = 1'b1; out_en[2] = 3'b111;
    @(posedge clk); #1;
    ready[2] = 1'b0;
    repeat (60) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    if (busy[2] !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy[2]); end
    n_cmp++;
    if (cwr[2] !== 1'b0 || csel[2] !== 2'b00) begin n_bad++; $display("FAIL rstmid_cwr got %b/%b want 0/00", cwr[2], csel[2]); end
    n_cmp++;
    if (iaddr_c !== 6'd0 || caddr_c !== 6'd0 || cdata[2] !== 8'd0) begin
      n_bad++; $display("FAIL rstmid_regs got %0d/%0d/%0d want 0/0/0", iaddr_c, caddr_c, cdata[2]);
    end
    n_cmp++;
    clear_log();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (nwr(2) !== 0) begin n_bad++; $display("FAIL rstmid_nowr got %0d want 0", nwr(2)); end
    n_cmp++;
    for (int i = 0; i < 64; i++) mem8[i] = 8'($urandom_range(0, 255));
    run(2, 3'b111, len);
    if (len !== 274) begin n_bad++; $display("FAIL rstmid_len got %0d want 274", len); end
    n_cmp++;
    if (nwr(2) !== 192) begin n_bad++; $display("FAIL rstmid_writes got %0d want 192", nwr(2)); end
    n_cmp++;
    check_gold8("rstmid_gold");
  endtask

  task automatic test_ready_held();
    int len1, len2, gap;
    for (int i = 0; i < 16; i++) mem4[i] = 8'(i * 13);
    @(posedge clk); #1;
    ready[0] = 1'b1; out_en[0] = 3'b111;
    @(posedge clk); #1;
    len1 = 0;
    while (busy[0] && len1 < 2000) begin len1++; @(posedge clk); #1; end
    gap = 0;
    while (!busy[0] && gap < 10) begin gap++; @(posedge clk); #1; end
    ready[0] = 1'b0;
    len2 = 0;
    while (busy[0] && len2 < 2000) begin len2++; @(posedge clk); #1; end
    if (len1 !== 74) begin n_bad++; $display("FAIL held_len1 got %0d want 74", len1); end
    n_cmp++;
    if (gap !== 1) begin n_bad++; $display("FAIL held_gap got %0d want 1", gap); end
    n_cmp++;
    if (len2 !== 74) begin n_bad++; $display("FAIL held_len2 got %0d want 74", len2); end
    n_cmp++;
  endtask

  initial begin
    ready = '0;
    out_en = '0;
    for (int i = 0; i < 16; i++) mem4[i] = 8'd0;
    for (int i = 0; i < 64; i++) mem8[i] = 8'd0;
    test_reset();
    test_flat4();
    test_abs4();
    test_edge8();
    test_y_only();
    test_reset_mid();
    test_ready_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sobel_lb.md
# sobel_lb

Line-buffered, parametrised Sobel edge engine that succeeds the fixed 256×256 SOBEL block. It streams a grayscale image once, in raster order, from the image memory, with one read per pixel. It keeps a 3×3 window in two line buffers and writes X-gradient, Y-gradient and combined results to the layer memories through the shared `csel`/`cwr` write port. Image size, data width, abs/clamp mode and per-run layer enables are selectable.

## Interface
- `IMG_W`, 256: image width in pixels, ≥3.
- `IMG_H`, 256: image height in pixels, ≥3.
- `DW`, 8: pixel and result width.
- `USE_ABS`, 0: 0 clamps negative gradients to 0; 1 uses |G| before clamping.
- `AW`, $clog2(IMG_W*IMG_H): image and layer address width.
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-high.
- `ready`  in  1: image available; start request, sampled in IDLE.
- `out_en`  in  3: layer enables, bit0 = X, bit1 = Y, bit2 = combined; sampled with `ready`; 3'b000 is treated as 3'b111.
- `busy`  out  1: high from the cycle after start until the last write completes.
- `iaddr`  out  AW: image read address, row*IMG_W+col.
- `idata`  in  DW: pixel at `iaddr` (combinational memory), sampled on the same rising edge.
- `cwr`  out  1: layer write strobe.
- `csel`  out  2: 01 = X layer, 10 = Y layer, 11 = combined, 00 = idle.
- `caddr_wr`  out  AW: layer write address, row*IMG_W+col.
- `cdata_wr`  out  DW: layer write data.

## Operation
- The engine scans a virtual raster of (IMG_H+1)×(IMG_W+1) positions (vr, vc).
  - At each position the input pixel is mem[vr][vc] if vr<IMG_H and vc<IMG_W; otherwise it is 0 and `iaddr` holds its value.
- The new pixel shifts into the window right column. The two line buffers (depth IMG_W+1) supply the upper rows.
  - Rows above row 0 and columns left of column 0 are masked to 0 by row and column valid flags. Line buffer RAM is never cleared.
- At vr≥1 and vc≥1 the window is centred on output (vr−1, vc−1), giving zero padding on all four borders.
- Window P0..P8 is row-major, with P4 as the centre.
  - Gx = (P0+2P3+P6) − (P2+2P5+P8).
  - Gy = (P0+2P1+P2) − (P6+2P7+P8).
  - Both are signed, DW+4 bits.
- Per-layer result: if USE_ABS, take |G|; else negative becomes 0. Then saturate to 2^DW−1.
- Combined = (X'+Y'+1)>>1, computed on the saturated X' and Y'. The width is DW+1 before the shift, so no overflow is possible.
- FSM states:
  - IDLE: on `ready` with `busy` low, latch `out_en` and go to READ.
  - READ: one cycle per virtual position; shift the window and line buffers. If an output is due, go to WRITE, else to READ or DONE.
  - WRITE: one cycle per enabled layer, in X, Y, combined order. After the last one, go to READ or DONE.
  - DONE: one cycle, `busy` falls, return to IDLE.
- `ready` is ignored while busy. A new run may start the cycle after DONE.

## Timing
- Reset values: `busy`=0, `cwr`=0, `csel`=00, `iaddr`=0, `caddr_wr`=0, `cdata_wr`=0. The FSM goes to IDLE and all window registers and flags are cleared.
- Reset mid-run aborts immediately with no further writes. The next run is not affected by stale line buffer data.
- `busy` rises on the first edge after `ready` is sampled in IDLE.
- Write cycle: `cwr`, `csel`, `caddr_wr` and `cdata_wr` are registered and valid together for exactly one cycle. There is no write back-pressure.
- Total run length = (IMG_H+1)(IMG_W+1) READ cycles + IMG_W·IMG_H·k WRITE cycles + 1 DONE cycle, where k = number of enabled layers.
  - Example: 256×256 with all layers gives 66049 + 196608 + 1 cycles.
- Output latency: output (r,c) is written immediately after pixel (r+1, c+1), or its padded position, is read.
- Row wrap: at vc=IMG_W the window's column valid flags reset for the next row. Combined with the left-column mask, this means no pixel leaks between rows.

## Structure
- The shared package holds:
  - CSEL_IDLE/X/Y/C constants.
  - The FSM state enum.
  - The gradient width function DW+4.
- One sub-module: `sobel_linebuf`, a parametrised (DW, IMG_W+1) two-row circular buffer with a single write/read pointer that wraps at IMG_W.
  - Gradient arithmetic and the FSM stay in `sobel_lb`.

## Test plan
- 4×4 image, all pixels 100, USE_ABS=0, out_en=111:
  - (0,0) → X=0, Y=0, C=0.
  - (1,1) → X=0, Y=0, C=0.
  - Exactly 48 writes in X, Y, C order per pixel.
- Same image with USE_ABS=1:
  - (0,0) has Gx=−300 and Gy=−300 → X=255, Y=255, C=255.
  - (1,1) → X=0, Y=0, C=0.
- 8×8 vertical edge (columns 0–3 = 0, columns 4–7 = 200), USE_ABS=1, at (3,3):
  - Gx=−800 → X=255, Y=0, C=128.
- out_en=010 on 256×256: only `csel`=10 writes, 65536 of them, and `busy` lasts 66049+65536+1 cycles.
- Assert `reset` midway through a run:
  - All outputs return to reset values the same cycle, `busy` is 0.
  - The following run on a new image matches the golden model exactly.
- Hold `ready` high through and after a run: no restart while busy; the next run begins the cycle after DONE.
